// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file for the 16-bit datapath.
// Reads are combinational, with optional hardwired-zero register 0 and optional write-to-read bypass.
module register_file_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_flag,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic [ADDR_W-1:0] r_addr_a,
    output logic [WIDTH-1:0]  r_data_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [WIDTH-1:0]  r_data_b
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             w_wrValid;
    logic             w_bypassA;
    logic             w_bypassB;
    logic [WIDTH-1:0] w_storedA;
    logic [WIDTH-1:0] w_storedB;

    // Out-of-range and hardwired-zero writes are dropped here, so they are never stored or bypassed.
    assign w_wrValid = rst_n && w_flag
                     && (int'(w_addr) < DEPTH)
                     && !((ZERO_REG != 0) && (w_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wrValid && (w_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                    r_regs[i] <= w_data;
                end
            end
        end
    end

    // Unmatched addresses fall through to zero, which covers out-of-range reads.
    always_comb begin
        w_storedA = '0;
        w_storedB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                if (r_addr_a == ADDR_W'(i)) begin
                    w_storedA = r_regs[i];
                end
                if (r_addr_b == ADDR_W'(i)) begin
                    w_storedB = r_regs[i];
                end
            end
        end
    end

    assign w_bypassA = (BYPASS != 0) && w_wrValid && (r_addr_a == w_addr);
    assign w_bypassB = (BYPASS != 0) && w_wrValid && (r_addr_b == w_addr);

    always_comb begin
        r_data_a = '0;
        r_data_b = '0;
        if (rst_n) begin
            r_data_a = w_bypassA ? w_data : w_storedA;
            r_data_b = w_bypassB ? w_data : w_storedB;
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: three configurations share one stimulus stream,
// checked against an array-based reference model of the read/write rules.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_flag;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic [3:0]  r_addr_a;
    logic [3:0]  r_addr_b;
    logic [15:0] rdA0, rdB0, rdA1, rdB1, rdA2, rdB2;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] model [3][16];

    always #5 clk = ~clk;

    register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .w_flag(w_flag), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_data_a(rdA0), .r_addr_b(r_addr_b), .r_data_b(rdB0));

    register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .w_flag(w_flag), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_data_a(rdA1), .r_addr_b(r_addr_b), .r_data_b(rdB1));

    register_file_2r1w #(.WIDTH(16), .DEPTH(12), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .w_flag(w_flag), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_data_a(rdA2), .r_addr_b(r_addr_b), .r_data_b(rdB2));

    function automatic int depthOf(input int c);
        return (c == 2) ? 12 : 16;
    endfunction

    function automatic bit zeroOf(input int c);
        return c != 1;
    endfunction

    function automatic bit bypassOf(input int c);
        return c != 1;
    endfunction

    function automatic bit writeOk(input int c);
        return rst_n && w_flag && (int'(w_addr) < depthOf(c)) && !(zeroOf(c) && (w_addr == 4'd0));
    endfunction

    function automatic logic [15:0] expRead(input int c, input logic [3:0] a);
        if (!rst_n) return 16'h0000;
        if (int'(a) >= depthOf(c)) return 16'h0000;
        if (zeroOf(c) && (a == 4'd0)) return 16'h0000;
        if (bypassOf(c) && writeOk(c) && (a == w_addr)) return w_data;
        return model[c][a];
    endfunction

    function automatic logic [15:0] portA(input int c);
        case (c)
            0:       return rdA0;
            1:       return rdA1;
            default: return rdA2;
        endcase
    endfunction

    function automatic logic [15:0] portB(input int c);
        case (c)
            0:       return rdB0;
            1:       return rdB1;
            default: return rdB2;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int c = 0; c < 3; c++) begin
            compare($sformatf("%s cfg%0d A@%0d", tag, c, r_addr_a), portA(c), expRead(c, r_addr_a));
            compare($sformatf("%s cfg%0d B@%0d", tag, c, r_addr_b), portB(c), expRead(c, r_addr_b));
        end
    endtask

    task automatic applyStimulus(input logic wf, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic [3:0] ra, input logic [3:0] rb);
        w_flag   = wf;
        w_addr   = wa;
        w_data   = wd;
        r_addr_a = ra;
        r_addr_b = rb;
    endtask

    task automatic tick();
        for (int c = 0; c < 3; c++) begin
            if (writeOk(c)) model[c][w_addr] = w_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetAssert();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 16; r++) model[c][r] = 16'h0000;
        end
    endtask

    initial begin
        resetAssert();
        applyStimulus(1'b0, 4'd0, 16'h0000, 4'd3, 4'd5);
        #1;
        checkOutput("reset-initial");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset clears stored data immediately, without a clock edge.
        applyStimulus(1'b1, 4'd3, 16'hAA55, 4'd3, 4'd3);
        tick();
        compare("load-reg3", rdA0, 16'hAA55);
        checkOutput("load-reg3");
        #2;
        resetAssert();
        #1;
        compare("async-reset reg3", rdA0, 16'h0000);
        checkOutput("async-reset");
        applyStimulus(1'b1, 4'd3, 16'h1111, 4'd3, 4'd4);
        tick();
        compare("reset-wins write", rdA2, 16'h0000);
        checkOutput("reset-wins");
        rst_n = 1'b1;
        #1;
        checkOutput("release-bypass");
        tick();
        applyStimulus(1'b0, 4'd3, 16'h1111, 4'd3, 4'd3);
        #1;
        compare("first-write-after-release", rdA1, 16'h1111);
        checkOutput("after-release");

        applyStimulus(1'b1, 4'd5, 16'hFF00, 4'd5, 4'd5);
        tick();
        applyStimulus(1'b0, 4'd5, 16'hFF00, 4'd5, 4'd5);
        #1;
        compare("write5 A", rdA0, 16'hFF00);
        compare("write5 B", rdB0, 16'hFF00);
        checkOutput("write5");

        applyStimulus(1'b0, 4'd5, 16'hFFFF, 4'd5, 4'd5);
        tick();
        tick();
        compare("hold FFFF", rdA1, 16'hFF00);
        checkOutput("hold-ffff");
        applyStimulus(1'b0, 4'd5, 16'hF0F0, 4'd5, 4'd5);
        tick();
        compare("hold F0F0", rdB2, 16'hFF00);
        checkOutput("hold-f0f0");

        applyStimulus(1'b1, 4'd0, 16'h1234, 4'd0, 4'd0);
        #1;
        compare("zero-reg pre-edge", rdA0, 16'h0000);
        checkOutput("zero-pre");
        tick();
        applyStimulus(1'b0, 4'd0, 16'h1234, 4'd0, 4'd0);
        #1;
        compare("zero-reg post-edge", rdA0, 16'h0000);
        compare("plain reg0 post-edge", rdA1, 16'h1234);
        checkOutput("zero-post");

        applyStimulus(1'b1, 4'd7, 16'h0001, 4'd7, 4'd2);
        tick();
        applyStimulus(1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd7);
        #1;
        compare("bypass on pre-edge", rdA0, 16'hBEEF);
        compare("bypass off pre-edge", rdB1, 16'h0001);
        checkOutput("bypass-pre");
        tick();
        applyStimulus(1'b0, 4'd7, 16'hBEEF, 4'd7, 4'd7);
        #1;
        compare("bypass on post-edge", rdA0, 16'hBEEF);
        compare("bypass off post-edge", rdB1, 16'hBEEF);
        checkOutput("bypass-post");

        // Address 13 lies beyond the 12-entry configuration.
        applyStimulus(1'b1, 4'd13, 16'h5A5A, 4'd13, 4'd13);
        #1;
        compare("range pre-edge", rdB2, 16'h0000);
        checkOutput("range-pre");
        tick();
        applyStimulus(1'b0, 4'd13, 16'h5A5A, 4'd13, 4'd13);
        #1;
        compare("range post-edge", rdB2, 16'h0000);
        compare("in-range cfg store13", rdB0, 16'h5A5A);
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'd13, 16'h5A5A, 4'(a), 4'(15 - a));
            #1;
            checkOutput("range-scan");
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)));
                #1;
                resetAssert();
                #1;
                checkOutput("rand-reset");
                rst_n = 1'b1;
                #1;
            end
            applyStimulus(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 16'($urandom),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) r_addr_a = w_addr;
            if ($urandom_range(0, 3) == 0) r_addr_b = w_addr;
            #1;
            checkOutput("rand-pre");
            tick();
            checkOutput("rand-post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
